// File: rtl/branch_pc_unit_pkg.sv
// Shared constants for the branch / PC unit: condition codes, flag bit
// positions and the FSM state encoding.
package branch_pc_unit_pkg;

    // Branch condition codes
    localparam logic [2:0] BR_NE = 3'd0;
    localparam logic [2:0] BR_EQ = 3'd1;
    localparam logic [2:0] BR_GT = 3'd2;
    localparam logic [2:0] BR_LT = 3'd3;
    localparam logic [2:0] BR_GE = 3'd4;
    localparam logic [2:0] BR_LE = 3'd5;
    localparam logic [2:0] BR_OV = 3'd6;
    localparam logic [2:0] BR_UN = 3'd7;

    // Positions inside the {Z, V, N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        PCU_RUN   = 2'd0,
        PCU_FLUSH = 2'd1,
        PCU_HALT  = 2'd2
    } pcu_state_e;

endpackage

// File: rtl/branch_pc_unit_cond.sv
// Combinational branch condition evaluator: decides whether a branch with
// code cond is taken given the ALU's registered {Z, V, N} flags.
module branch_cond_eval
    import branch_pc_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flag,
    output logic       take
);

    logic z;
    logic v;
    logic n;

    assign z = flag[FLAG_Z];
    assign v = flag[FLAG_V];
    assign n = flag[FLAG_N];

    // Decode the condition code against the flags
    always_comb begin
        take = 1'b0;
        case (cond)
            BR_NE:   take = !z;
            BR_EQ:   take = z;
            BR_GT:   take = !z && !n;
            BR_LT:   take = n;
            BR_GE:   take = !n;
            BR_LE:   take = z || n;
            BR_OV:   take = v;
            BR_UN:   take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter owner: resolves conditional branches, register jumps and
// HALT, and raises a flush window squashing wrong-path fetches after a
// redirect.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter int               ASIZE        = 16,
    parameter int               FLUSH_CYCLES = 2,
    parameter logic [ASIZE-1:0] RESET_PC     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [7:0]       br_offset,
    input  logic [ASIZE-1:0] br_pc,
    input  logic             jr_valid,
    input  logic [ASIZE-1:0] jr_target,
    input  logic             halt_req,
    input  logic [2:0]       flag,
    output logic [ASIZE-1:0] pc,
    output logic             flush,
    output logic             taken,
    output logic             halted
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);

    // Branch target: br_pc + 1 + sign-extended word offset, wrapping
    function automatic logic [ASIZE-1:0] branch_target(
        input logic [ASIZE-1:0]  base,
        input logic signed [7:0] off
    );
        logic signed [ASIZE-1:0] off_ext;
        off_ext = ASIZE'(off);
        return base + ASIZE'(1) + $unsigned(off_ext);
    endfunction

    pcu_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [ASIZE-1:0] pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             br_take;
    logic             redirect;
    logic [ASIZE-1:0] redirect_pc;

    branch_cond_eval u_cond (
        .cond (br_cond),
        .flag (flag),
        .take (br_take)
    );

    // JR outranks a branch; both only matter when no HALT is pending
    assign redirect    = jr_valid || (br_valid && br_take);
    assign redirect_pc = jr_valid ? jr_target : branch_target(br_pc, $signed(br_offset));

    // Next-state, next-PC and flush counter selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        if (!stall) begin
            case (state_q)
                PCU_RUN: begin
                    if (halt_req) begin
                        state_d = PCU_HALT;
                    end else if (redirect) begin
                        pc_d    = redirect_pc;
                        taken_d = 1'b1;
                        if (HAS_FLUSH) begin
                            state_d = PCU_FLUSH;
                            cnt_d   = FLUSH_LOAD;
                        end
                    end else begin
                        pc_d = pc_q + ASIZE'(1);
                    end
                end
                PCU_FLUSH: begin
                    // Wrong-path control instructions are ignored here
                    pc_d  = pc_q + ASIZE'(1);
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = PCU_RUN;
                    end
                end
                PCU_HALT: begin
                    state_d = PCU_HALT;
                end
                default: begin
                    state_d = PCU_RUN;
                end
            endcase
        end
    end

    // State, PC, counter and taken pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PCU_RUN;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    assign pc     = pc_q;
    assign taken  = taken_q;
    assign flush  = (state_q == PCU_FLUSH);
    assign halted = (state_q == PCU_HALT);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: two instances (FLUSH_CYCLES=2 and 0) share the
// stimulus; a behavioural model predicts both every cycle, and directed
// literal expectations pin the model.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [7:0]  br_offset;
    logic [15:0] br_pc;
    logic        jr_valid;
    logic [15:0] jr_target;
    logic        halt_req;
    logic [2:0]  flag;

    logic [15:0] pc_a, pc_b;
    logic        flush_a, flush_b, taken_a, taken_b, halted_a, halted_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_pc_unit #(.ASIZE(16), .FLUSH_CYCLES(2), .RESET_PC(16'h0000)) u_a (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_cond(br_cond),
        .br_offset(br_offset), .br_pc(br_pc), .jr_valid(jr_valid), .jr_target(jr_target),
        .halt_req(halt_req), .flag(flag), .pc(pc_a), .flush(flush_a), .taken(taken_a),
        .halted(halted_a)
    );

    branch_pc_unit #(.ASIZE(16), .FLUSH_CYCLES(0), .RESET_PC(16'h0000)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_cond(br_cond),
        .br_offset(br_offset), .br_pc(br_pc), .jr_valid(jr_valid), .jr_target(jr_target),
        .halt_req(halt_req), .flag(flag), .pc(pc_b), .flush(flush_b), .taken(taken_b),
        .halted(halted_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int fc    [2] = '{2, 0};
    int mpc   [2] = '{0, 0};
    int mleft [2] = '{0, 0};   // wrong-path slots still to squash
    bit mhalt [2] = '{0, 0};
    bit mtaken[2] = '{0, 0};

    function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void model_step(input int i);
        int off;
        mtaken[i] = 1'b0;
        if (stall || mhalt[i]) return;
        if (mleft[i] > 0) begin
            mpc[i] = (mpc[i] + 1) & 'hFFFF;
            mleft[i] = mleft[i] - 1;
            return;
        end
        if (halt_req) begin
            mhalt[i] = 1'b1;
        end else if (jr_valid) begin
            mpc[i] = int'(jr_target);
            mtaken[i] = 1'b1;
            mleft[i] = fc[i];
        end else if (br_valid && cond_true(br_cond, flag)) begin
            off = int'($signed(br_offset));
            mpc[i] = (int'(br_pc) + 1 + off) & 'hFFFF;
            mtaken[i] = 1'b1;
            mleft[i] = fc[i];
        end else begin
            mpc[i] = (mpc[i] + 1) & 'hFFFF;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mpc[i] = 0; mleft[i] = 0; mhalt[i] = 1'b0; mtaken[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("pc_a",     pc_a,     mpc[0]);
        check("flush_a",  flush_a,  mleft[0] > 0);
        check("taken_a",  taken_a,  mtaken[0]);
        check("halted_a", halted_a, mhalt[0]);
        check("pc_b",     pc_b,     mpc[1]);
        check("flush_b",  flush_b,  mleft[1] > 0);
        check("taken_b",  taken_b,  mtaken[1]);
        check("halted_b", halted_b, mhalt[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        br_valid = 1'b0; jr_valid = 1'b0; halt_req = 1'b0; stall = 1'b0;
    endtask

    initial begin
        logic [2:0] flist [5];
        flist = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101};
        rst = 1'b1;
        idle();
        br_cond = 3'd0; br_offset = 8'd0; br_pc = 16'd0; jr_target = 16'd0; flag = 3'd0;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("run3_pc", pc_a, 16'h0003);

        // asynchronous reset mid-run
        rst = 1'b1;
        #1;
        check("arst_pc", pc_a, 16'h0000);
        check("arst_flush", flush_a, 1'b0);
        check("arst_taken", taken_a, 1'b0);
        check("arst_halted", halted_a, 1'b0);
        rst = 1'b0;
        tick(3);
        check("rerun_pc", pc_a, 16'h0003);

        // EQ taken, forward offset
        br_valid = 1'b1; br_cond = 3'b001; flag = 3'b100; br_pc = 16'h0010; br_offset = 8'h05;
        tick(1);
        check("eq_pc", pc_a, 16'h0016);
        check("eq_taken", taken_a, 1'b1);
        check("eq_flush", flush_a, 1'b1);
        check("eq_flush_b", flush_b, 1'b0);
        br_valid = 1'b0;
        tick(1);
        check("eq_pc1", pc_a, 16'h0017);
        check("eq_flush1", flush_a, 1'b1);
        check("eq_taken1", taken_a, 1'b0);
        tick(1);
        check("eq_flush2", flush_a, 1'b0);
        tick(1);
        check("eq_pc3", pc_a, 16'h0019);

        // backward branch wrapping below zero, then sequential wrap
        br_valid = 1'b1; br_cond = 3'b111; br_pc = 16'h0001; br_offset = 8'hFC;
        tick(1);
        check("back_pc", pc_a, 16'hFFFE);
        br_valid = 1'b0;
        tick(2);
        check("wrap_pc", pc_a, 16'h0000);

        // GT not taken with N set
        br_valid = 1'b1; br_cond = 3'b010; flag = 3'b001;
        tick(1);
        check("nt_pc", pc_a, 16'h0001);
        check("nt_taken", taken_a, 1'b0);
        check("nt_flush", flush_a, 1'b0);

        // control instructions ignored inside FLUSH, stall freezes it
        br_cond = 3'b111; br_pc = 16'h0040; br_offset = 8'h00;
        tick(1);
        check("ign_entry", pc_a, 16'h0041);
        halt_req = 1'b1; br_pc = 16'h0100;
        tick(1);
        check("ign_pc", pc_a, 16'h0042);
        check("ign_halted", halted_a, 1'b0);
        check("ign_b_halted", halted_b, 1'b1);
        stall = 1'b1;
        tick(3);
        check("stall_pc", pc_a, 16'h0042);
        check("stall_flush", flush_a, 1'b1);
        stall = 1'b0;
        tick(1);
        check("ign_exit_pc", pc_a, 16'h0043);
        check("ign_exit_flush", flush_a, 1'b0);
        check("ign_exit_halted", halted_a, 1'b0);
        idle();
        tick(1);

        // priority: HALT beats JR and branch
        halt_req = 1'b1; jr_valid = 1'b1; jr_target = 16'h1234; br_valid = 1'b1;
        tick(1);
        check("prio_pc", pc_a, 16'h0044);
        check("prio_halted", halted_a, 1'b1);
        idle();
        jr_valid = 1'b1;
        tick(2);
        check("halt_hold_pc", pc_a, 16'h0044);
        jr_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("halt_rst_halted", halted_a, 1'b0);
        check("halt_rst_pc", pc_a, 16'h0000);
        rst = 1'b0;
        tick(1);
        check("after_rst_pc", pc_b, 16'h0001);

        // OV with zero-length flush window
        br_valid = 1'b1; br_cond = 3'b110; flag = 3'b010; br_pc = 16'h0020; br_offset = 8'h10;
        tick(1);
        check("ov_pc_b", pc_b, 16'h0031);
        check("ov_taken_b", taken_b, 1'b1);
        check("ov_flush_b", flush_b, 1'b0);
        br_valid = 1'b0;
        tick(2);
        check("ov_pc2_b", pc_b, 16'h0033);
        br_valid = 1'b1; flag = 3'b000;
        tick(1);
        check("ovnt_pc_b", pc_b, 16'h0034);
        check("ovnt_taken_b", taken_b, 1'b0);
        br_valid = 1'b0;

        // JR redirect
        jr_valid = 1'b1; jr_target = 16'hBEEF;
        tick(1);
        check("jr_pc", pc_a, 16'hBEEF);
        jr_valid = 1'b0;
        tick(2);

        // stall in RUN blocks a pending branch
        stall = 1'b1; br_valid = 1'b1; br_cond = 3'b111;
        tick(2);
        idle();
        tick(1);

        // sweep of all condition codes against several flag patterns
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 5; f++) begin
                br_valid = 1'b1; br_cond = 3'(c); flag = flist[f];
                br_pc = 16'h0100 + 16'(c * 16); br_offset = 8'hF0 + 8'(f);
                tick(1);
                br_valid = 1'b0;
                tick(2);
            end
        end

        tick(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Downstream consumer of the ALU's registered condition flags (flag[2:0] = {Z, V, N}).
- Owns the program counter and resolves conditional branches, register jumps (JR) and HALT.
- Evaluates the branch condition against the flags, computes the next PC and emits a registered flush window that squashes the wrong-path instructions already fetched.

Parameters:
- ASIZE, 16, PC / instruction-address width.
- FLUSH_CYCLES, 2, number of wrong-path slots squashed after a redirect (legal range 0..7).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  freeze: no state change while high.
- br_valid  input  1  a branch instruction is in the resolve slot.
- br_cond  input  3  branch condition code.
- br_offset  input  8  signed word offset, relative to br_pc+1.
- br_pc  input  ASIZE  address of the branch instruction.
- jr_valid  input  1  register jump is in the resolve slot.
- jr_target  input  ASIZE  absolute jump target.
- halt_req  input  1  HALT instruction is in the resolve slot.
- flag  input  3  {Z, V, N} from the ALU, already registered.
- pc  output  ASIZE  current fetch address (registered).
- flush  output  1  high while in FLUSH (registered).
- taken  output  1  one-cycle pulse on the cycle after a redirect.
- halted  output  1  high in HALT (registered).

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=RUN, cnt=0, flush=0, taken=0, halted=0.
  - Reset overrides every state, including mid-FLUSH and HALT.
- Condition evaluation (combinational, on the flag value in the same cycle as br_valid):
  - 000 NE: Z==0.
  - 001 EQ: Z==1.
  - 010 GT: Z==0 && N==0.
  - 011 LT: N==1.
  - 100 GE: N==0.
  - 101 LE: Z==1 || N==1.
  - 110 OV: V==1.
  - 111 UN: always true.
- Target arithmetic:
  - target = br_pc + 1 + sign_extend(br_offset), modulo 2^ASIZE.
  - Sequential pc+1 also wraps: 16'hFFFF -> 16'h0000.
- States: RUN, FLUSH, HALT.
- taken defaults to 0 every clock unless a redirect occurs.
- Any state with stall=1: all registers hold, and taken is forced to 0.
- RUN with stall=0, inputs checked in priority order halt_req > jr_valid > br_valid:
  - halt_req: state->HALT, pc holds, halted<=1.
  - jr_valid: pc<=jr_target, taken<=1. If FLUSH_CYCLES>0, state->FLUSH and cnt<=FLUSH_CYCLES; otherwise stay in RUN.
  - br_valid with condition true: pc<=target, taken<=1, FLUSH entry as for JR.
  - br_valid with condition false: pc<=pc+1, taken<=0.
  - none asserted: pc<=pc+1.
- FLUSH with stall=0:
  - pc<=pc+1 (fetching down the new path); flush=1.
  - br_valid, jr_valid and halt_req are ignored, because those instructions are wrong-path.
  - cnt decrements; when cnt==1, state->RUN on this edge.
- HALT:
  - pc frozen, halted=1, flush=0.
  - Exit only via rst.
- Latency:
  - Redirect is visible on pc one edge after the resolve cycle.
  - flush is high for exactly FLUSH_CYCLES non-stalled cycles after that edge.

Decomposition:
- Shared define file:
  - condition codes `BR_NE .. `BR_UN.
  - flag bit indices `FLAG_Z=2, `FLAG_V=1, `FLAG_N=0.
  - state encodings `PCU_RUN, `PCU_FLUSH, `PCU_HALT.
- One combinational sub-module: branch_cond_eval (inputs cond[2:0], flag[2:0]; output take).
- The top module holds the PC, the flush counter and the FSM.

Test Plan:
- Reset: rst=1 mid-run -> pc=0x0000, flush=0, taken=0, halted=0 immediately (async). Release, 3 clocks -> pc=0x0003.
- EQ taken: br_valid=1, br_cond=001, flag=3'b100, br_pc=0x0010, br_offset=0x05 -> next pc=0x0016, taken pulses 1 cycle, flush=1 for 2 cycles, then RUN with pc=0x0019.
- Backward and not-taken:
  - br_pc=0x0001, br_offset=0xFC, cond=111 -> pc=0xFFFE (wrap).
  - cond=010, flag=3'b001 -> not taken, pc=pc+1, flush stays 0.
- Ignore during flush: in FLUSH, assert br_valid (cond 111) and halt_req -> no redirect, no HALT, cnt continues. stall=1 for 3 cycles inside FLUSH -> pc and cnt frozen, flush held at 1.
- Priority: halt_req, jr_valid(0x1234) and br_valid all asserted together in RUN -> HALT, pc unchanged, halted=1. Later rst -> RUN at 0x0000.
- OV and FLUSH_CYCLES=0: cond=110, flag=3'b010 -> taken with flush never asserted. Same stimulus with flag=3'b000 -> not taken.
